// File: rtl/text_pkg.sv
// Shared types and widths for the text sprite fetch block.
//   ADDR_W : text ROM address width
//   PIX_W  : bits per text pixel
//   DIM_W  : sprite width/height counter width
//   CALC_W : width of the intermediate address sum
//   pix_t  : pixel plus end-of-row / end-of-sprite tags
//   state_t: fetch FSM states
package text_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned PIX_W  = 2;
  localparam int unsigned DIM_W  = 6;
  localparam int unsigned CALC_W = 16;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             last;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/text_pix_fifo.sv
// Two-entry pixel FIFO between the ROM return path and the pixel stream.
//   Clk, Reset_n : clock, async active-low reset (empties FIFO, zeroes storage)
//   push/push_data : write one tagged pixel
//   pop            : remove head entry (caller guarantees not_empty)
//   head           : current head entry, stable until popped
//   not_empty      : head is valid
//   count          : occupancy 0..2
module text_pix_fifo
  import text_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       push,
  input  pix_t       push_data,
  input  logic       pop,
  output pix_t       head,
  output logic       not_empty,
  output logic [1:0] count
);

  pix_t       mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;

  // Storage and pointers; simultaneous push and pop keep the count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (cnt_q != 2'd0);
  assign count     = cnt_q;

endmodule

// File: rtl/text_sprite_fetch.sv
// Fetches a w x h sprite from the text ROM in row-major order and streams
// its pixels with valid/ready handshake and end-of-row / end-of-sprite tags.
//   Clk, Reset_n          : clock, async active-low reset
//   cmd_valid/cmd_ready   : request handshake (ready only when idle)
//   cmd_base/cmd_w/cmd_h  : top-left ROM address, width, height
//   rom_addr / rom_data   : ROM read port, data one cycle after address
//   pix_valid/pix_ready   : pixel stream handshake
//   pix_data/pix_eol/pix_last : pixel and its tags
//   busy / done / oob     : active, completion pulse, sticky out-of-range
module text_sprite_fetch
  import text_pkg::*;
#(
  parameter int unsigned SHEET_W  = 400,
  parameter int unsigned ROM_LAST = 10000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [DIM_W-1:0]  cmd_w,
  input  logic [DIM_W-1:0]  cmd_h,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              oob
);

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [DIM_W-1:0]    w_q;
  logic [DIM_W-1:0]    h_q;
  logic [DIM_W-1:0]    col_q;
  logic [DIM_W-1:0]    row_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                rd_vld_q;
  logic                rd_eol_q;
  logic                rd_last_q;
  logic                rd_oob_q;
  logic                oob_q;
  logic                done_q;
  logic                busy_q;
  logic                cmd_ready_q;

  logic                accept_c;
  logic                empty_cmd_c;
  logic [CALC_W-1:0]   addr_full_c;
  logic                addr_oob_c;
  logic                col_end_c;
  logic                row_end_c;
  logic                pop_c;
  logic [1:0]          occ_c;
  logic                issue_c;
  logic                final_issue_c;
  logic                last_pop_c;

  pix_t                push_px;
  pix_t                head_px;
  logic                fifo_ne;
  logic [1:0]          fifo_cnt;

  assign accept_c    = (state_q == IDLE) && cmd_valid;
  assign empty_cmd_c = (cmd_w == '0) || (cmd_h == '0);

  // Address of the current col/row; 16 bits covers the largest sum.
  assign addr_full_c = CALC_W'(base_q) + CALC_W'(row_q) * CALC_W'(SHEET_W)
                     + CALC_W'(col_q);
  assign addr_oob_c  = (addr_full_c > CALC_W'(ROM_LAST));
  assign col_end_c   = (col_q == w_q - DIM_W'(1));
  assign row_end_c   = (row_q == h_q - DIM_W'(1));

  assign pop_c      = fifo_ne && pix_ready;
  assign last_pop_c = pop_c && head_px.last;

  // Reads in flight plus buffered pixels, crediting a pixel leaving now,
  // so the FIFO can never be overrun whatever the consumer does.
  assign occ_c = 2'(rd_vld_q) + fifo_cnt - 2'(pop_c);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept_c && !empty_cmd_c) state_nxt = FETCH;
      FETCH:   if (final_issue_c)            state_nxt = DRAIN;
      DRAIN:   if (last_pop_c)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue decision and ROM address; the address holds when not issuing.
  always_comb begin
    issue_c       = 1'b0;
    final_issue_c = 1'b0;
    rom_addr      = last_addr_q;
    if (state_q == FETCH && occ_c < 2'd2) begin
      issue_c       = 1'b1;
      final_issue_c = col_end_c && row_end_c;
      rom_addr      = addr_full_c[ADDR_W-1:0];
    end
  end

  // Sprite counters, read tracking and status flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q      <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      last_addr_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_eol_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_oob_q    <= 1'b0;
      oob_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (accept_c) begin
        base_q <= cmd_base;
        w_q    <= cmd_w;
        h_q    <= cmd_h;
        col_q  <= '0;
        row_q  <= '0;
        oob_q  <= 1'b0;
      end else begin
        if (issue_c) begin
          if (col_end_c) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        if (rd_vld_q && rd_oob_q) begin
          oob_q <= 1'b1;
        end
      end
      if (issue_c) begin
        last_addr_q <= addr_full_c[ADDR_W-1:0];
      end
      rd_vld_q    <= issue_c;
      rd_eol_q    <= col_end_c;
      rd_last_q   <= final_issue_c;
      rd_oob_q    <= addr_oob_c;
      done_q      <= (accept_c && empty_cmd_c) || ((state_q == DRAIN) && last_pop_c);
      busy_q      <= (state_nxt != IDLE);
      cmd_ready_q <= (state_nxt == IDLE);
    end
  end

  // Returning ROM data; out-of-range reads are replaced with zero.
  always_comb begin
    push_px      = '0;
    push_px.data = rd_oob_q ? '0 : rom_data;
    push_px.eol  = rd_eol_q;
    push_px.last = rd_last_q;
  end

  text_pix_fifo u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (rd_vld_q),
    .push_data (push_px),
    .pop       (pop_c),
    .head      (head_px),
    .not_empty (fifo_ne),
    .count     (fifo_cnt)
  );

  assign pix_valid = fifo_ne;
  assign pix_data  = head_px.data;
  assign pix_eol   = head_px.eol;
  assign pix_last  = head_px.last;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign oob       = oob_q;

endmodule
